// File: rtl/kd_tree_sequencer.sv
// kd_tree_sequencer
// Control sequencer for a k-d tree clustering engine built from a heap-shaped
// array of processing elements (PE 0 is the root, PE i has parent (i-1)/2).
// A run sorts the tree level by level with odd/even compare-swap phases,
// repeats whole-tree rounds while swaps keep happening (bounded by tree_depth
// rounds), streams n_points points through the array, then issues a
// center-update strobe. Iterations repeat until converged or max_iter.
//
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous active-low reset
//   start          begin a run (sampled in IDLE only)
//   n_points       points per iteration (captured on start)
//   converged      centers unchanged (sampled in UPDATE)
//   swap_req       per-PE comparator result; bit i asks PE i to swap with its parent
//   pt_valid       point source has a point
//   pt_ready       point accepted this cycle (FETCH and pt_valid)
//   en             PE array enable
//   receive_point  PE array loads the presented point
//   inc            point accumulate strobe
//   sorting        a sort phase is active
//   next_level     sort moved down one level
//   parent_switch  per-PE: swap with parent
//   child_switch   per-PE: swap with a child
//   level          tree level currently being sorted
//   update         center-update strobe
//   iter           completed iterations
//   busy           run in progress
//   done           run finished (one cycle)
module kd_tree_sequencer #(
  parameter int dim        = 3,
  parameter int data_range = 255,
  parameter int max_n      = 1000,
  parameter int max_depth  = 16,
  parameter int tree_depth = 3,
  parameter int max_iter   = 16,
  localparam int n_pe         = (1 << tree_depth) - 1,
  localparam int counter_size = $clog2(max_n),
  localparam int depth_size   = $clog2(max_depth),
  localparam int iter_size    = $clog2(max_iter + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [counter_size-1:0] n_points,
  input  logic                    converged,
  input  logic [n_pe-1:0]         swap_req,
  input  logic                    pt_valid,
  output logic                    pt_ready,
  output logic                    en,
  output logic                    receive_point,
  output logic                    inc,
  output logic                    sorting,
  output logic                    next_level,
  output logic [n_pe-1:0]         parent_switch,
  output logic [n_pe-1:0]         child_switch,
  output logic [depth_size-1:0]   level,
  output logic                    update,
  output logic [iter_size-1:0]    iter,
  output logic                    busy,
  output logic                    done
);

  // Point geometry belongs to the PE datapath; the sequencer never looks at it.
  localparam int unused_geometry = dim * data_range;

  // Extra whole-tree rounds allowed after the first one.
  localparam int round_size = (tree_depth < 1) ? 1 : $clog2(tree_depth + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SORT_L = 3'd1,
    SORT_R = 3'd2,
    FETCH  = 3'd3,
    ACCUM  = 3'd4,
    UPDATE = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Tree level of heap node idx (root is level 0).
  function automatic int node_level(input int idx);
    return $clog2(idx + 2) - 1;
  endfunction

  state_t                  state_r, state_next_s;
  logic [depth_size-1:0]   level_r, level_next_s;
  logic [iter_size-1:0]    iter_r, iter_next_s, iter_inc_s;
  logic [round_size-1:0]   rounds_r, rounds_next_s;
  logic [counter_size-1:0] count_r, count_next_s, count_inc_s;
  logic [counter_size-1:0] n_points_r, n_points_next_s;
  logic                    round_swapped_r, round_swapped_next_s;
  logic                    swapped_so_far_s;
  logic                    next_level_next_s;
  logic [n_pe-1:0]         sel_s;
  logic [n_pe-1:0]         child_sel_s;
  logic                    odd_phase_s;
  logic                    sort_active_s;
  logic                    unused_root_req_s;

  logic en_r, sorting_r, next_level_r, inc_r, update_r, busy_r, done_r;

  // The root has no parent, so its request bit carries no meaning.
  assign unused_root_req_s = swap_req[0];

  assign sort_active_s = (state_r == SORT_L) || (state_r == SORT_R);
  assign odd_phase_s   = (state_r == SORT_L);
  assign iter_inc_s    = iter_r + iter_size'(1);
  assign count_inc_s   = count_r + counter_size'(1);

  // Select the PEs of the current level and phase that asked to swap; odd and
  // even siblings are split across phases so no parent sees two children.
  always_comb begin
    sel_s       = '0;
    child_sel_s = '0;
    for (int i = 1; i < n_pe; i++) begin
      sel_s[i] = sort_active_s && (node_level(i) == int'(level_r)) &&
                 (((i % 2) == 1) == odd_phase_s) && swap_req[i];
      child_sel_s[(i - 1) / 2] = child_sel_s[(i - 1) / 2] | sel_s[i];
    end
  end

  assign swapped_so_far_s = round_swapped_r | (|sel_s);

  // Next-state and next-counter logic.
  always_comb begin
    state_next_s         = state_r;
    level_next_s         = level_r;
    iter_next_s          = iter_r;
    rounds_next_s        = rounds_r;
    count_next_s         = count_r;
    n_points_next_s      = n_points_r;
    round_swapped_next_s = round_swapped_r;
    next_level_next_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s         = SORT_L;
          n_points_next_s      = n_points;
          iter_next_s          = '0;
          level_next_s         = depth_size'(1);
          rounds_next_s        = '0;
          count_next_s         = '0;
          round_swapped_next_s = 1'b0;
        end else begin
          state_next_s = IDLE;
        end
      end
      SORT_L: begin
        round_swapped_next_s = swapped_so_far_s;
        state_next_s         = SORT_R;
      end
      SORT_R: begin
        round_swapped_next_s = swapped_so_far_s;
        if (level_r < depth_size'(tree_depth - 1)) begin
          level_next_s      = level_r + depth_size'(1);
          next_level_next_s = 1'b1;
          state_next_s      = SORT_L;
        end else if (swapped_so_far_s && (rounds_r < round_size'(tree_depth - 1))) begin
          // rounds_r counts rounds started after the first, so the total stays
          // within tree_depth rounds.
          round_swapped_next_s = 1'b0;
          level_next_s         = depth_size'(1);
          rounds_next_s        = rounds_r + round_size'(1);
          state_next_s         = SORT_L;
        end else begin
          count_next_s = '0;
          if (n_points_r == '0) begin
            state_next_s = UPDATE;
          end else begin
            state_next_s = FETCH;
          end
        end
      end
      FETCH: begin
        if (pt_valid) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = FETCH;
        end
      end
      ACCUM: begin
        count_next_s = count_inc_s;
        if (count_inc_s == n_points_r) begin
          state_next_s = UPDATE;
        end else begin
          state_next_s = FETCH;
        end
      end
      UPDATE: begin
        iter_next_s = iter_inc_s;
        if (converged || (iter_inc_s == iter_size'(max_iter))) begin
          state_next_s = DONE;
        end else begin
          level_next_s         = depth_size'(1);
          rounds_next_s        = '0;
          round_swapped_next_s = 1'b0;
          state_next_s         = SORT_L;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, counters and registered strobes; strobes are decoded from the
  // state being entered so they line up with that state's cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= IDLE;
      level_r         <= '0;
      iter_r          <= '0;
      rounds_r        <= '0;
      count_r         <= '0;
      n_points_r      <= '0;
      round_swapped_r <= 1'b0;
      en_r            <= 1'b0;
      sorting_r       <= 1'b0;
      next_level_r    <= 1'b0;
      inc_r           <= 1'b0;
      update_r        <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      level_r         <= level_next_s;
      iter_r          <= iter_next_s;
      rounds_r        <= rounds_next_s;
      count_r         <= count_next_s;
      n_points_r      <= n_points_next_s;
      round_swapped_r <= round_swapped_next_s;
      en_r            <= (state_next_s != IDLE) && (state_next_s != DONE);
      sorting_r       <= (state_next_s == SORT_L) || (state_next_s == SORT_R);
      next_level_r    <= next_level_next_s;
      inc_r           <= (state_next_s == ACCUM);
      update_r        <= (state_next_s == UPDATE);
      busy_r          <= (state_next_s != IDLE);
      done_r          <= (state_next_s == DONE);
    end
  end

  // Handshake and swap controls must react within the same cycle, so they are
  // decoded from the registered state and the live inputs.
  assign pt_ready      = (state_r == FETCH) && pt_valid;
  assign receive_point = pt_ready;
  assign parent_switch = sel_s;
  assign child_switch  = child_sel_s;

  assign en         = en_r;
  assign sorting    = sorting_r;
  assign next_level = next_level_r;
  assign inc        = inc_r;
  assign update     = update_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign level      = level_r;
  assign iter       = iter_r;

endmodule

// File: tb/tb_kd_tree_sequencer.sv
// Bench for kd_tree_sequencer with tree_depth=3 (7 PEs) and max_iter=4.
// Inputs change 1 time unit after the rising edge, outputs are sampled 2 units
// after it. flags packs {en, sorting, next_level, receive_point, inc, update,
// done, busy}.
module tb_kd_tree_sequencer;
  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       start     = 1'b0;
  logic [9:0] n_points  = 10'd0;
  logic       converged = 1'b0;
  logic [6:0] swap_req  = 7'd0;
  logic       pt_valid  = 1'b0;
  logic       pt_ready, en, receive_point, inc, sorting, next_level;
  logic       update, busy, done;
  logic [6:0] parent_switch, child_switch;
  logic [3:0] level;
  logic [2:0] iter;
  logic [7:0] flags;
  int tests_run    = 0;
  int tests_failed = 0;

  assign flags = {en, sorting, next_level, receive_point, inc, update, done, busy};

  always #5 clk = ~clk;

  kd_tree_sequencer #(.max_iter(4)) dut (
    .clk(clk), .rst(rst), .start(start), .n_points(n_points),
    .converged(converged), .swap_req(swap_req), .pt_valid(pt_valid),
    .pt_ready(pt_ready), .en(en), .receive_point(receive_point), .inc(inc),
    .sorting(sorting), .next_level(next_level), .parent_switch(parent_switch),
    .child_switch(child_switch), .level(level), .update(update), .iter(iter),
    .busy(busy), .done(done)
  );

  // Pulse start for one cycle from IDLE; returns at sample time of SORT_L cycle 0.
  task automatic launch(input logic [9:0] np);
    @(posedge clk); #1;
    n_points = np;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if (flags !== 8'h00) begin tests_failed++; $display("FAIL reset_flags got=%h exp=%h", flags, 8'h00); end
    tests_run++;
    if ({parent_switch, child_switch, pt_ready} !== 15'd0) begin tests_failed++; $display("FAIL reset_switch got=%h exp=0", {parent_switch, child_switch, pt_ready}); end
    tests_run++;
    if ({level, iter} !== 7'd0) begin tests_failed++; $display("FAIL reset_level_iter got=%h exp=0", {level, iter}); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      tests_run++;
      if (flags !== 8'h00) begin tests_failed++; $display("FAIL post_reset_idle k=%0d got=%h exp=%h", k, flags, 8'h00); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_flags [11];
    exp_flags = '{8'hC1, 8'hC1, 8'hE1, 8'hC1, 8'h91, 8'h89, 8'h91, 8'h89, 8'h85, 8'h03, 8'h00};
    swap_req  = 7'd0;
    converged = 1'b1;
    pt_valid  = 1'b1;
    launch(10'd2);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) begin @(posedge clk); #2; end
      tests_run++;
      if (flags !== exp_flags[k]) begin tests_failed++; $display("FAIL basic_flags k=%0d got=%h exp=%h", k, flags, exp_flags[k]); end
      tests_run++;
      if (pt_ready !== exp_flags[k][4]) begin tests_failed++; $display("FAIL basic_pt_ready k=%0d got=%b exp=%b", k, pt_ready, exp_flags[k][4]); end
      if (k < 4) begin
        tests_run++;
        if (level !== ((k < 2) ? 4'd1 : 4'd2)) begin tests_failed++; $display("FAIL basic_level k=%0d got=%0d", k, level); end
      end
      if (k >= 8) begin
        tests_run++;
        if (iter !== ((k == 8) ? 3'd0 : 3'd1)) begin tests_failed++; $display("FAIL basic_iter k=%0d got=%0d", k, iter); end
      end
    end
    pt_valid = 1'b0;
  endtask

  task automatic test_swap();
    logic [6:0] exp_p;
    logic [6:0] exp_c;
    swap_req  = 7'b0000110;
    converged = 1'b1;
    pt_valid  = 1'b1;
    launch(10'd0);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) begin @(posedge clk); #2; end
      exp_p = 7'd0;
      exp_c = 7'd0;
      if (k < 12 && (k % 4) == 0) begin exp_p = 7'h02; exp_c = 7'h01; end
      if (k < 12 && (k % 4) == 1) begin exp_p = 7'h04; exp_c = 7'h01; end
      tests_run++;
      if (parent_switch !== exp_p || child_switch !== exp_c) begin
        tests_failed++;
        $display("FAIL swap_switch k=%0d got=%h/%h exp=%h/%h", k, parent_switch, child_switch, exp_p, exp_c);
      end
      tests_run++;
      if ((parent_switch & child_switch) !== 7'd0) begin tests_failed++; $display("FAIL swap_overlap k=%0d got=%h exp=0", k, parent_switch & child_switch); end
      tests_run++;
      if (flags !== ((k < 12) ? (((k % 4) == 2) ? 8'hE1 : 8'hC1) : ((k == 12) ? 8'h85 : 8'h03))) begin
        tests_failed++;
        $display("FAIL swap_flags k=%0d got=%h", k, flags);
      end
      tests_run++;
      if (pt_ready !== 1'b0) begin tests_failed++; $display("FAIL swap_no_ready k=%0d got=%b exp=0", k, pt_ready); end
    end
    swap_req = 7'd0;
    pt_valid = 1'b0;
  endtask

  task automatic test_stuck();
    logic [6:0] exp_p [4];
    logic [6:0] exp_c [4];
    logic [7:0] exp_tail [4];
    exp_p    = '{7'h02, 7'h04, 7'h28, 7'h50};
    exp_c    = '{7'h01, 7'h01, 7'h06, 7'h06};
    exp_tail = '{8'h91, 8'h89, 8'h85, 8'h03};
    swap_req  = 7'h7F;
    converged = 1'b1;
    pt_valid  = 1'b1;
    launch(10'd1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin @(posedge clk); #2; end
      tests_run++;
      if (flags !== ((k < 12) ? (((k % 4) == 2) ? 8'hE1 : 8'hC1) : exp_tail[k - 12])) begin
        tests_failed++;
        $display("FAIL stuck_flags k=%0d got=%h", k, flags);
      end
      if (k < 12) begin
        tests_run++;
        if (parent_switch !== exp_p[k % 4] || child_switch !== exp_c[k % 4]) begin
          tests_failed++;
          $display("FAIL stuck_switch k=%0d got=%h/%h exp=%h/%h", k, parent_switch, child_switch, exp_p[k % 4], exp_c[k % 4]);
        end
        tests_run++;
        if (level !== (((k % 4) < 2) ? 4'd1 : 4'd2)) begin tests_failed++; $display("FAIL stuck_level k=%0d got=%0d", k, level); end
      end
      tests_run++;
      if ((parent_switch & child_switch) !== 7'd0) begin tests_failed++; $display("FAIL stuck_overlap k=%0d got=%h exp=0", k, parent_switch & child_switch); end
    end
    swap_req = 7'd0;
    pt_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic       pv_tab [12];
    logic [7:0] exp_flags [12];
    int incs;
    pv_tab    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_flags = '{8'hC1, 8'hC1, 8'hE1, 8'hC1, 8'h91, 8'h89, 8'h81, 8'h81, 8'h91, 8'h89, 8'h85, 8'h03};
    incs      = 0;
    swap_req  = 7'd0;
    converged = 1'b1;
    pt_valid  = 1'b0;
    launch(10'd2);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; pt_valid = pv_tab[k]; #1; end
      if (inc === 1'b1) incs++;
      tests_run++;
      if (flags !== exp_flags[k]) begin tests_failed++; $display("FAIL stall_flags k=%0d got=%h exp=%h", k, flags, exp_flags[k]); end
      tests_run++;
      if (pt_ready !== exp_flags[k][4]) begin tests_failed++; $display("FAIL stall_pt_ready k=%0d got=%b exp=%b", k, pt_ready, exp_flags[k][4]); end
    end
    tests_run++;
    if (incs !== 2) begin tests_failed++; $display("FAIL stall_inc_count got=%0d exp=2", incs); end
    pt_valid = 1'b0;
  endtask

  task automatic test_start_ignored();
    int  incs;
    int  dones;
    logic seen_idle;
    incs      = 0;
    dones     = 0;
    seen_idle = 1'b0;
    swap_req  = 7'd0;
    converged = 1'b1;
    pt_valid  = 1'b1;
    launch(10'd1);
    for (int k = 0; k < 40 && !seen_idle; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start    = (k >= 1 && k <= 3);
        n_points = (k >= 1 && k <= 3) ? 10'd5 : 10'd1;
        #1;
      end
      if (inc === 1'b1) incs++;
      if (done === 1'b1) dones++;
      if (k > 0 && busy === 1'b0) seen_idle = 1'b1;
    end
    start = 1'b0;
    tests_run++;
    if (seen_idle !== 1'b1) begin tests_failed++; $display("FAIL start_ign_timeout got=%b exp=1", seen_idle); end
    tests_run++;
    if (incs !== 1) begin tests_failed++; $display("FAIL start_ign_incs got=%0d exp=1", incs); end
    tests_run++;
    if (dones !== 1) begin tests_failed++; $display("FAIL start_ign_dones got=%0d exp=1", dones); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL start_ign_idle k=%0d got=%b exp=0", k, busy); end
    end
    pt_valid = 1'b0;
  endtask

  task automatic test_max_iter();
    int  updates;
    int  dones;
    int  done_k;
    logic [2:0] iter_at_done;
    logic seen_idle;
    updates      = 0;
    dones        = 0;
    done_k       = -1;
    iter_at_done = 3'd0;
    seen_idle    = 1'b0;
    swap_req     = 7'd0;
    converged    = 1'b0;
    pt_valid     = 1'b0;
    launch(10'd0);
    for (int k = 0; k < 40 && !seen_idle; k++) begin
      if (k > 0) begin @(posedge clk); #2; end
      if (update === 1'b1) updates++;
      if (done === 1'b1) begin dones++; done_k = k; iter_at_done = iter; end
      if (k == 5) begin
        tests_run++;
        if (level !== 4'd1 || sorting !== 1'b1) begin tests_failed++; $display("FAIL max_iter_relevel got=%0d/%b exp=1/1", level, sorting); end
      end
      if (k > 0 && busy === 1'b0) seen_idle = 1'b1;
    end
    tests_run++;
    if (seen_idle !== 1'b1) begin tests_failed++; $display("FAIL max_iter_timeout got=%b exp=1", seen_idle); end
    tests_run++;
    if (updates !== 4) begin tests_failed++; $display("FAIL max_iter_updates got=%0d exp=4", updates); end
    tests_run++;
    if (dones !== 1 || done_k !== 20) begin tests_failed++; $display("FAIL max_iter_done got=%0d@%0d exp=1@20", dones, done_k); end
    tests_run++;
    if (iter_at_done !== 3'd4) begin tests_failed++; $display("FAIL max_iter_iter got=%0d exp=4", iter_at_done); end
    converged = 1'b1;
  endtask

  task automatic test_reset_mid();
    swap_req  = 7'd0;
    converged = 1'b1;
    pt_valid  = 1'b1;
    launch(10'd3);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #2;
    end
    tests_run++;
    if (flags !== 8'h89) begin tests_failed++; $display("FAIL mid_in_accum got=%h exp=%h", flags, 8'h89); end
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if (flags !== 8'h00) begin tests_failed++; $display("FAIL mid_reset_flags got=%h exp=%h", flags, 8'h00); end
    tests_run++;
    if ({parent_switch, child_switch, pt_ready, level, iter} !== 22'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_state got=%h exp=0", {parent_switch, child_switch, pt_ready, level, iter});
    end
    @(posedge clk);
    #3 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      tests_run++;
      if (flags !== 8'h00 || pt_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_post_idle k=%0d got=%h exp=%h", k, flags, 8'h00); end
    end
    pt_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_stuck();
    test_stall();
    test_start_ignored();
    test_max_iter();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
